// File: rtl/layer_output_serializer.sv
// layer_output_serializer
// Collects the parallel results of one neuron layer and replays them, one word
// per clock, into the next layer.
//
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   in_data    num_neurons*data_width results; neuron k in [k*data_width +: data_width]
//   in_valid   per-neuron outvalid pulses; bit k qualifies slice k
//   out_data   serialized result (registered; holds its value between frames)
//   out_valid  out_data carries a valid element this cycle
//   out_last   high together with element num_neurons-1
//   busy       high while the frame is being shifted out
//   overrun    sticky; some in_valid bit arrived while shifting and was dropped
//
// Handshake: there is no ready on either side. An in_valid bit is consumed on
// the edge that samples it; out_valid words are taken by the next layer on the
// cycle they appear, with no way to stall.
module layer_output_serializer #(
   parameter int num_neurons = 30,
   parameter int data_width  = 16,
   localparam int idx_width  = (num_neurons > 1) ? $clog2(num_neurons) : 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [num_neurons*data_width-1:0] in_data,
   input  logic [num_neurons-1:0]            in_valid,
   output logic [data_width-1:0]             out_data,
   output logic                              out_valid,
   output logic                              out_last,
   output logic                              busy,
   output logic                              overrun
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      SHIFT   = 2'd2
   } state_t;

   localparam logic [idx_width-1:0] last_idx = idx_width'(num_neurons - 1);

   state_t                  state;
   state_t                  state_next;
   logic [num_neurons-1:0]  mask;
   logic [num_neurons-1:0]  seen;
   logic [idx_width-1:0]    idx;
   logic [data_width-1:0]   data_buf [num_neurons];

   // Neurons reported so far, including those reporting on this edge.
   assign seen = mask | in_valid;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, COLLECT: begin
            if (&seen)      state_next = SHIFT;
            else if (|seen) state_next = COLLECT;
            else            state_next = IDLE;
         end
         SHIFT: begin
            if (idx == last_idx) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Capture storage has no reset: contents only matter once the mask says so.
   always_ff @(posedge clk) begin
      for (int k = 0; k < num_neurons; k++) begin
         if (state != SHIFT && in_valid[k])
            data_buf[k] <= in_data[k*data_width +: data_width];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mask      <= '0;
         idx       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         busy <= (state_next == SHIFT);
         if (state == SHIFT) begin
            out_data  <= data_buf[idx];
            out_valid <= 1'b1;
            out_last  <= (idx == last_idx);
            idx       <= idx + 1'b1;
            // Inputs are ignored while shifting, including on the final edge.
            if (|in_valid) overrun <= 1'b1;
         end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (&seen) begin
               mask <= '0;
               idx  <= '0;
            end else begin
               mask <= seen;
            end
         end
      end
   end

endmodule

// File: tb/tb_layer_output_serializer.sv
// Bench for layer_output_serializer: one 4-neuron and one 1-neuron instance.
// Each instance has a schedule-based model: a completed capture at edge T
// books element k for edge T+1+k; inputs at edges T+1..T+N are dropped and
// flag overrun; busy is expected after edges T..T+N-1.
module tb_layer_output_serializer;

  typedef struct {
    int          cyc;
    logic [15:0] d;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_data_a  [2];
  logic [3:0]  in_valid_a [2];
  logic [15:0] out_data_a [2];
  logic        out_valid_a[2];
  logic        out_last_a [2];
  logic        busy_a     [2];
  logic        overrun_a  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int N = (g == 0) ? 4 : 1;

    layer_output_serializer #(.num_neurons(N), .data_width(16)) dut (
      .clk(clk),
      .rst(rst),
      .in_data(in_data_a[g][N*16-1:0]),
      .in_valid(in_valid_a[g][N-1:0]),
      .out_data(out_data_a[g]),
      .out_valid(out_valid_a[g]),
      .out_last(out_last_a[g]),
      .busy(busy_a[g]),
      .overrun(overrun_a[g])
    );

    logic [15:0]  m_val [N];
    logic [N-1:0] m_mask = '0;
    logic         m_ovr = 1'b0;
    logic [15:0]  last_d = '0;
    int           t_enter = -1000;
    int           e = 0;
    exp_t         exp_q[$];
    logic         s_rst;
    logic [N-1:0] s_v;
    logic [63:0]  s_d;

    always begin
      @(posedge clk);
      s_rst = rst;
      s_v   = in_valid_a[g][N-1:0];
      s_d   = in_data_a[g];
      e++;
      if (s_rst) begin
        m_mask  = '0;
        m_ovr   = 1'b0;
        last_d  = '0;
        t_enter = -1000;
        exp_q.delete();
      end else if (e >= t_enter + 1 && e <= t_enter + N) begin
        if (s_v != '0) m_ovr = 1'b1;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (s_v[k]) begin
            m_val[k]  = s_d[k*16 +: 16];
            m_mask[k] = 1'b1;
          end
        end
        if (&m_mask) begin
          t_enter = e;
          m_mask  = '0;
          for (int k = 0; k < N; k++) exp_q.push_back('{e + 1 + k, m_val[k], (k == N - 1)});
        end
      end
      #1;
      if (exp_q.size() > 0 && exp_q[0].cyc == e) begin
        chk($sformatf("n%0d out_valid", N), 32'(out_valid_a[g]), 32'd1);
        chk($sformatf("n%0d out_data", N), 32'(out_data_a[g]), 32'(exp_q[0].d));
        chk($sformatf("n%0d out_last", N), 32'(out_last_a[g]), 32'(exp_q[0].last));
        last_d = exp_q[0].d;
        void'(exp_q.pop_front());
      end else begin
        chk($sformatf("n%0d idle out_valid", N), 32'(out_valid_a[g]), 32'd0);
        chk($sformatf("n%0d idle out_last", N), 32'(out_last_a[g]), 32'd0);
        chk($sformatf("n%0d held out_data", N), 32'(out_data_a[g]), 32'(last_d));
      end
      chk($sformatf("n%0d busy", N), 32'(busy_a[g]),
          32'((e >= t_enter && e <= t_enter + N - 1) ? 1 : 0));
      chk($sformatf("n%0d overrun", N), 32'(overrun_a[g]), 32'(m_ovr));
    end
  end

  task automatic idle_inputs();
    in_valid_a[0] = '0;
    in_valid_a[1] = '0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    in_data_a[0]  = '0;
    in_data_a[1]  = '0;
    idle_inputs();
    cycles(2);
    rst = 1'b0;
    cycles(2);

    // All four neurons report in one cycle.
    in_valid_a[0] = 4'hf;
    in_data_a[0]  = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    @(negedge clk);
    idle_inputs();
    chk("t1 busy at entry", 32'(busy_a[0]), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1 data", 32'(out_data_a[0]), 32'(k + 1));
      chk("t1 valid", 32'(out_valid_a[0]), 32'd1);
      chk("t1 last", 32'(out_last_a[0]), 32'((k == 3) ? 1 : 0));
    end
    @(negedge clk);
    chk("t1 valid after", 32'(out_valid_a[0]), 32'd0);
    chk("t1 overrun", 32'(overrun_a[0]), 32'd0);
    cycles(2);

    // Staggered arrival: bit0 at c0, bits1-2 at c3, bit3 at c7.
    for (int c = 0; c < 8; c++) begin
      in_valid_a[0] = (c == 0) ? 4'b0001 : (c == 3) ? 4'b0110 : (c == 7) ? 4'b1000 : 4'b0000;
      in_data_a[0]  = {$urandom, $urandom};
      @(negedge clk);
      chk("t2 no early valid", 32'(out_valid_a[0]), 32'd0);
    end
    idle_inputs();
    cycles(6);

    // Overwrite of neuron 1 before the frame completes.
    in_valid_a[0] = 4'b0010;
    in_data_a[0]  = {16'h0, 16'h0, 16'h1111, 16'h0};
    @(negedge clk);
    in_valid_a[0] = 4'b0010;
    in_data_a[0]  = {16'h0, 16'h0, 16'h2222, 16'h0};
    @(negedge clk);
    in_valid_a[0] = 4'b1101;
    in_data_a[0]  = {16'hd003, 16'hd002, 16'h9999, 16'hd000};
    @(negedge clk);
    idle_inputs();
    cycles(2);
    chk("t3 element1 overwritten", 32'(out_data_a[0]), 32'h2222);
    cycles(4);

    // Overrun: a pulse during the second output cycle is dropped.
    in_valid_a[0] = 4'hf;
    in_data_a[0]  = {16'ha004, 16'ha003, 16'ha002, 16'ha001};
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    in_valid_a[0] = 4'b0001;
    in_data_a[0]  = {48'h0, 16'hdead};
    @(negedge clk);
    idle_inputs();
    chk("t4 overrun set", 32'(overrun_a[0]), 32'd1);
    cycles(4);
    in_valid_a[0] = 4'b1110;
    in_data_a[0]  = {16'hb004, 16'hb003, 16'hb002, 16'h0};
    @(negedge clk);
    idle_inputs();
    cycles(3);
    chk("t4 overrun sticky", 32'(overrun_a[0]), 32'd1);
    in_valid_a[0] = 4'b0001;
    in_data_a[0]  = {48'h0, 16'hb001};
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    chk("t4 next frame elem0", 32'(out_data_a[0]), 32'hb001);
    cycles(5);

    // Reset after two elements of a frame.
    in_valid_a[0] = 4'hf;
    in_data_a[0]  = {16'hc004, 16'hc003, 16'hc002, 16'hc001};
    @(negedge clk);
    idle_inputs();
    cycles(2);
    chk("t5 second element", 32'(out_data_a[0]), 32'hc002);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5 valid after rst", 32'(out_valid_a[0]), 32'd0);
    chk("t5 busy after rst", 32'(busy_a[0]), 32'd0);
    chk("t5 overrun after rst", 32'(overrun_a[0]), 32'd0);
    cycles(4);

    // Single-neuron instance.
    in_valid_a[1] = 4'b0001;
    in_data_a[1]  = {48'h0, 16'hbeef};
    @(negedge clk);
    idle_inputs();
    chk("n1 busy", 32'(busy_a[1]), 32'd1);
    @(negedge clk);
    chk("n1 data", 32'(out_data_a[1]), 32'hbeef);
    chk("n1 valid", 32'(out_valid_a[1]), 32'd1);
    chk("n1 last", 32'(out_last_a[1]), 32'd1);
    chk("n1 busy low", 32'(busy_a[1]), 32'd0);
    @(negedge clk);
    chk("n1 valid after", 32'(out_valid_a[1]), 32'd0);

    // Random traffic on both instances with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int g = 0; g < 2; g++) begin
        for (int b = 0; b < 4; b++) in_valid_a[g][b] = ($urandom_range(0, 3) == 0);
        in_data_a[g] = {$urandom, $urandom};
      end
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    idle_inputs();
    cycles(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_output_serializer.md
Name: layer_output_serializer

Overview:
- Sits between one neuron layer and the next in the MNIST fixed-point network.
- Captures the num_neurons parallel neuron results, each qualified by that neuron's own outvalid pulse. Once every neuron has reported, replays the results one per clock as a serial stream.
- The serial stream (out_data/out_valid) drives the myinput/myinput_valid inputs of every neuron in the following layer.
- No backpressure: downstream neurons consume one word per cycle unconditionally.

Parameters:
- num_neurons, 30, number of neurons in the producing layer; legal range ≥1.
- data_width, 16, width of one neuron result (signed fixed-point, passed through unmodified).
- idx_width, max(1,$clog2(num_neurons)), width of internal element index; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_data  in  num_neurons*data_width  neuron results; neuron k occupies bits [k*data_width +: data_width].
- in_valid  in  num_neurons  per-neuron outvalid; bit k qualifies slice k.
- out_data  out  data_width  serialized result, registered.
- out_valid  out  1  out_data holds a valid element this cycle.
- out_last  out  1  high with the final element (index num_neurons-1) of a frame.
- busy  out  1  high while in SHIFT state.
- overrun  out  1  sticky: an in_valid bit was dropped during SHIFT; cleared only by rst.

Behaviour:
- Reset (rst sampled high at an edge): state=IDLE; capture mask=0; idx=0; out_data=0; out_valid=0; out_last=0; busy=0; overrun=0. Buffer contents are don't-care. Reset mid-SHIFT aborts the frame; no further out_valid until a new full capture completes.
- States:
  - IDLE: mask=0.
  - COLLECT: mask nonzero, not yet full.
  - SHIFT: emitting elements.
- Capture (IDLE or COLLECT):
  - At each edge, for every k with in_valid[k]=1, buf[k]<=in_data slice k and mask[k]<=1.
  - A repeated valid for an already-captured k overwrites buf[k]; this is not an error.
- Transitions:
  - IDLE->COLLECT when some in_valid bits are set but (mask|in_valid) is not all ones.
  - IDLE/COLLECT->SHIFT at the edge where (mask|in_valid) becomes all ones. This includes the case where all bits arrive in the same cycle, which goes directly from IDLE. At that edge: idx<=0, mask<=0.
- Emission:
  - Let T be the edge that entered SHIFT.
  - At edge T+1+k (k=0..num_neurons-1): out_data<=buf[k], out_valid<=1, out_last<=(k==num_neurons-1).
  - Elements are emitted in index order, neuron 0 first, on consecutive cycles with no gaps.
  - The edge emitting the last element also moves state to IDLE.
  - At edge T+num_neurons+1: out_valid<=0, out_last<=0. out_data holds its last value.
- busy: registered. High from edge T through edge T+num_neurons-1 inclusive; low again after edge T+num_neurons.
- Overrun: any in_valid bit sampled while state=SHIFT is dropped, with no buffer or mask update, and sets overrun<=1.
  - in_valid sampled at the edge leaving SHIFT is also dropped.
  - The first accepted capture is at edge T+num_neurons+1.
- num_neurons=1: element 0 is emitted at edge T+1 with out_valid=1 and out_last=1 together; back to IDLE at the same edge.
- No arithmetic: data passes through bit-exact, no saturation or sign handling.
- Latency: element 0 appears one cycle after the capture-completing edge. A full frame occupies num_neurons consecutive out_valid cycles.

Test Plan (num_neurons=4, data_width=16 unless noted):
- All in_valid=4'b1111 in one cycle with data {0x0004,0x0003,0x0002,0x0001} (neuron3..0) -> next cycles out_data 0x0001,0x0002,0x0003,0x0004 with out_valid=1; out_last only on 0x0004; out_valid=0 afterwards; overrun=0.
- Staggered valids: bit0 at cycle 0, bits1–2 at cycle 3, bit3 at cycle 7 -> no out_valid before the edge after cycle 7; then 4 contiguous elements in neuron order.
- Overwrite: bit1 valid twice (0x1111 then 0x2222) before completion -> element 1 emits 0x2222.
- Overrun: in_valid=4'b0001 asserted during the second SHIFT output cycle -> overrun=1 and stays 1; that word does not appear in the next frame. A later full 4'b1111 capture still serializes correctly.
- Reset mid-SHIFT after 2 elements -> out_valid=0, busy=0, overrun=0 at the next edge; no remaining elements emitted.
- num_neurons=1, in_valid=1 with data 0xBEEF -> one cycle with out_data=0xBEEF, out_valid=1, out_last=1; busy was high for one cycle.
